// File: rtl/lcd_pkg.sv
// Shared constants, opcode classes and address-counter stepping for the HD44780 responder.
package lcd_pkg;

  localparam logic [7:0] LCD_SPACE   = 8'h20;
  localparam logic [6:0] LINE2_BASE  = 7'h40;
  localparam logic [6:0] LINE_LEN_2L = 7'h28;
  localparam logic [6:0] LINE_LEN_1L = 7'h50;

  localparam logic [7:0] OP_MASK_DDRAM = 8'h80;
  localparam logic [7:0] OP_MASK_CGRAM = 8'h40;
  localparam logic [7:0] OP_MASK_FUNC  = 8'h20;
  localparam logic [7:0] OP_MASK_SHIFT = 8'h10;
  localparam logic [7:0] OP_MASK_DISP  = 8'h08;
  localparam logic [7:0] OP_MASK_ENTRY = 8'h04;
  localparam logic [7:0] OP_MASK_HOME  = 8'h02;
  localparam logic [7:0] OP_MASK_CLEAR = 8'h01;

  typedef enum logic [3:0] {
    OP_NOP, OP_CLEAR, OP_HOME, OP_ENTRY, OP_DISP, OP_SHIFT, OP_FUNC, OP_CGRAM, OP_DDRAM
  } op_e;

  typedef enum logic {PH_HIGH, PH_LOW} phase_e;

  function automatic op_e decode_op(input logic [7:0] b);
    if ((b & OP_MASK_DDRAM) != '0) return OP_DDRAM;
    if ((b & OP_MASK_CGRAM) != '0) return OP_CGRAM;
    if ((b & OP_MASK_FUNC)  != '0) return OP_FUNC;
    if ((b & OP_MASK_SHIFT) != '0) return OP_SHIFT;
    if ((b & OP_MASK_DISP)  != '0) return OP_DISP;
    if ((b & OP_MASK_ENTRY) != '0) return OP_ENTRY;
    if ((b & OP_MASK_HOME)  != '0) return OP_HOME;
    if ((b & OP_MASK_CLEAR) != '0) return OP_CLEAR;
    return OP_NOP;
  endfunction

  // Out-of-range addresses (from a raw set-address) always recover to 0x00.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc,
                                         input logic two_line);
    logic [6:0] base;
    logic [6:0] off;
    if (two_line) begin
      base = ac[6] ? LINE2_BASE : 7'h00;
      off  = ac - base;
      if (off >= LINE_LEN_2L) return 7'h00;
      if (inc)
        return (off == LINE_LEN_2L - 7'd1) ? (ac[6] ? 7'h00 : LINE2_BASE) : ac + 7'd1;
      return (off == 7'd0) ? (ac[6] ? LINE_LEN_2L - 7'd1 : LINE2_BASE + LINE_LEN_2L - 7'd1)
                           : ac - 7'd1;
    end
    if (ac >= LINE_LEN_1L) return 7'h00;
    if (inc) return (ac == LINE_LEN_1L - 7'd1) ? 7'h00 : ac + 7'd1;
    return (ac == 7'd0) ? LINE_LEN_1L - 7'd1 : ac - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// Character image store: one write port, one registered read port (read-before-write).
module lcd_ddram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/lcd_sink.sv
// HD44780-style bus responder: synchronises the bus, rebuilds bytes, executes them into a DDRAM image.
module lcd_sink #(
  parameter int unsigned COLS = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      lcd_en,
  input  logic                      lcd_rs,
  input  logic [3:0]                lcd_data,
  input  logic [$clog2(2*COLS)-1:0] rd_addr,
  output logic [7:0]                rd_data,
  output logic                      cmd_valid,
  output logic                      cmd_rs,
  output logic [7:0]                cmd_byte,
  output logic                      busy,
  output logic                      four_bit,
  output logic                      two_line,
  output logic                      disp_on,
  output logic                      cursor_on,
  output logic                      blink_on,
  output logic [6:0]                ddram_addr,
  output logic                      overrun
);
  import lcd_pkg::*;

  localparam int unsigned DEPTH = 2 * COLS;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [1:0] en_sync, rs_sync;
  logic [3:0] d_meta, d_sync;
  logic       en_prev, strobe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_sync <= '0;
      rs_sync <= '0;
      d_meta  <= '0;
      d_sync  <= '0;
      en_prev <= 1'b0;
    end else begin
      en_sync <= {en_sync[0], lcd_en};
      rs_sync <= {rs_sync[0], lcd_rs};
      d_meta  <= lcd_data;
      d_sync  <= d_meta;
      en_prev <= en_sync[1];
    end
  end

  assign strobe = en_prev & ~en_sync[1];

  phase_e        phase;
  logic [3:0]    hi_nib;
  logic          hi_rs;
  logic          inc_mode;
  logic [AW-1:0] fill_cnt;

  // The byte registered on the strobe cycle is executed one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid  <= 1'b0;
      cmd_rs     <= 1'b0;
      cmd_byte   <= '0;
      busy       <= 1'b1;
      four_bit   <= 1'b0;
      two_line   <= 1'b0;
      disp_on    <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      ddram_addr <= '0;
      overrun    <= 1'b0;
      phase      <= PH_HIGH;
      hi_nib     <= '0;
      hi_rs      <= 1'b0;
      inc_mode   <= 1'b1;
      fill_cnt   <= '0;
    end else begin
      cmd_valid <= 1'b0;
      if (busy) begin
        if (fill_cnt == AW'(DEPTH - 1)) busy <= 1'b0;
        else                            fill_cnt <= fill_cnt + 1'b1;
      end
      if (strobe) begin
        if (busy) begin
          overrun <= 1'b1;
        end else if (!four_bit) begin
          cmd_valid <= 1'b1;
          cmd_rs    <= rs_sync[1];
          cmd_byte  <= {d_sync, 4'h0};
        end else if (phase == PH_HIGH) begin
          hi_nib <= d_sync;
          hi_rs  <= rs_sync[1];
          phase  <= PH_LOW;
        end else begin
          cmd_valid <= 1'b1;
          cmd_rs    <= hi_rs;
          cmd_byte  <= {hi_nib, d_sync};
          phase     <= PH_HIGH;
        end
      end
      if (cmd_valid) begin
        if (cmd_rs) begin
          ddram_addr <= ac_step(ddram_addr, inc_mode, two_line);
        end else begin
          unique case (decode_op(cmd_byte))
            OP_DDRAM: ddram_addr <= cmd_byte[6:0];
            OP_FUNC: begin
              four_bit <= ~cmd_byte[4];
              two_line <= cmd_byte[3];
              phase    <= PH_HIGH;
            end
            OP_SHIFT: if (!cmd_byte[3]) ddram_addr <= ac_step(ddram_addr, cmd_byte[2], two_line);
            OP_DISP: begin
              disp_on   <= cmd_byte[2];
              cursor_on <= cmd_byte[1];
              blink_on  <= cmd_byte[0];
            end
            OP_ENTRY: inc_mode <= cmd_byte[1];
            OP_HOME:  ddram_addr <= '0;
            OP_CLEAR: begin
              ddram_addr <= '0;
              inc_mode   <= 1'b1;
              busy       <= 1'b1;
              fill_cnt   <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  logic [6:0]    col, map_idx7;
  logic          map_ok;
  logic          img_we;
  logic [AW-1:0] img_waddr;
  logic [7:0]    img_wdata;

  always_comb begin
    col      = {1'b0, ddram_addr[5:0]};
    map_ok   = 1'b0;
    map_idx7 = '0;
    if (two_line) begin
      map_ok   = col < 7'(COLS);
      map_idx7 = ddram_addr[6] ? col + 7'(COLS) : col;
    end else begin
      map_ok   = ddram_addr < 7'(DEPTH);
      map_idx7 = ddram_addr;
    end
  end

  always_comb begin
    img_we    = 1'b0;
    img_waddr = '0;
    img_wdata = LCD_SPACE;
    if (busy) begin
      img_we    = 1'b1;
      img_waddr = fill_cnt;
    end else if (cmd_valid && cmd_rs && map_ok) begin
      img_we    = 1'b1;
      img_waddr = AW'(map_idx7);
      img_wdata = cmd_byte;
    end
  end

  lcd_ddram #(.DEPTH(DEPTH), .AW(AW)) u_ddram (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (img_we),
    .waddr (img_waddr),
    .wdata (img_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_lcd_sink.sv
// Bench for lcd_sink: drives the nibble bus and compares against an address-sequence model of the controller.
module tb_lcd_sink;

  localparam int unsigned COLS  = 16;
  localparam int unsigned DEPTH = 2 * COLS;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          lcd_en = 1'b0;
  logic          lcd_rs = 1'b0;
  logic [3:0]    lcd_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data, cmd_byte;
  logic          cmd_valid, cmd_rs, busy, four_bit, two_line, disp_on, cursor_on, blink_on, overrun;
  logic [6:0]    ddram_addr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  lcd_sink #(.COLS(COLS)) dut (
    .clk(clk), .reset_n(reset_n), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_data(lcd_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .cmd_valid(cmd_valid), .cmd_rs(cmd_rs),
    .cmd_byte(cmd_byte), .busy(busy), .four_bit(four_bit), .two_line(two_line),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .ddram_addr(ddram_addr), .overrun(overrun)
  );

  // Reference state
  bit         m_four, m_two, m_disp, m_cur, m_blink, m_id, m_busy, m_over, m_phase_low, m_hi_rs;
  bit [3:0]   m_hi;
  int         m_ac;
  logic [7:0] m_img [DEPTH];
  int         m_cv_count = 0;
  logic [7:0] rd_at_exec, exp_rd_exec;

  int mon_cv_count = 0, mon_run = 0, mon_last_run = 0;

  always @(negedge clk) begin
    if (!reset_n) mon_run = 0;
    else if (busy) mon_run++;
    else if (mon_run > 0) begin
      mon_last_run = mon_run;
      mon_run = 0;
    end
    if (cmd_valid === 1'b1) mon_cv_count++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Addresses form one 80-entry ring in both modes; -1 marks an address outside it.
  function automatic int lin_pos(int ac, bit two);
    if (two) begin
      if (ac < 40) return ac;
      if (ac >= 64 && ac < 104) return ac - 24;
      return -1;
    end
    return (ac < 80) ? ac : -1;
  endfunction

  function automatic int step_ac(int ac, bit inc, bit two);
    int p = lin_pos(ac, two);
    int np;
    if (p < 0) return 0;
    np = (p + (inc ? 1 : 79)) % 80;
    if (two && np >= 40) return np + 24;
    return np;
  endfunction

  function automatic int img_idx(int ac, bit two);
    if (two) return ((ac % 64) < COLS) ? (ac / 64) * COLS + (ac % 64) : -1;
    return (ac < DEPTH) ? ac : -1;
  endfunction

  function automatic void model_reset();
    m_four = 0; m_two = 0; m_disp = 0; m_cur = 0; m_blink = 0;
    m_id = 1; m_busy = 1; m_over = 0; m_phase_low = 0; m_ac = 0;
    for (int i = 0; i < DEPTH; i++) m_img[i] = 8'h20;
  endfunction

  function automatic void model_exec(bit rs, logic [7:0] b);
    int i;
    if (rs) begin
      i = img_idx(m_ac, m_two);
      if (i >= 0) m_img[i] = b;
      m_ac = step_ac(m_ac, m_id, m_two);
    end else if (b >= 128) m_ac = int'(b) - 128;
    else if (b >= 64) begin end
    else if (b >= 32) begin m_four = !b[4]; m_two = b[3]; m_phase_low = 0; end
    else if (b >= 16) begin if (!b[3]) m_ac = step_ac(m_ac, b[2], m_two); end
    else if (b >= 8) begin m_disp = b[2]; m_cur = b[1]; m_blink = b[0]; end
    else if (b >= 4) m_id = b[1];
    else if (b >= 2) m_ac = 0;
    else if (b == 1) begin
      m_ac = 0; m_id = 1; m_busy = 1;
      for (int k = 0; k < DEPTH; k++) m_img[k] = 8'h20;
    end
  endfunction

  function automatic logic [13:0] model_vec();
    return {m_four, m_two, m_disp, m_cur, m_blink, m_over, m_busy, 7'(m_ac)};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {four_bit, two_line, disp_on, cursor_on, blink_on, overrun, busy, ddram_addr};
  endfunction

  task automatic send_nibble(input bit rs, input logic [3:0] nib);
    bit done = 0;
    bit exp_rs = 0;
    logic [7:0] exp_b = '0, obs_b = '0;
    logic obs_rs = 1'b0;
    logic [2:0] cv_seen = '0;
    if (m_busy) m_over = 1;
    else if (!m_four) begin done = 1; exp_b = {nib, 4'h0}; exp_rs = rs; end
    else if (!m_phase_low) begin m_hi = nib; m_hi_rs = rs; m_phase_low = 1; end
    else begin done = 1; exp_b = {m_hi, nib}; exp_rs = m_hi_rs; m_phase_low = 0; end
    lcd_rs = rs; lcd_data = nib; lcd_en = 1'b1;
    repeat (3) tick();
    lcd_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      cv_seen[k] = cmd_valid;
      if (k == 2) begin obs_b = cmd_byte; obs_rs = cmd_rs; end
    end
    n_checks++;
    if (cv_seen !== (done ? 3'b100 : 3'b000)) begin
      n_fail++;
      $display("FAIL cmd_valid_timing: got %b expected %b", cv_seen, done ? 3'b100 : 3'b000);
    end
    if (done) begin
      n_checks++;
      m_cv_count++;
      if (obs_b !== exp_b || obs_rs !== exp_rs) begin
        n_fail++;
        $display("FAIL cmd_byte: got rs=%b %h expected rs=%b %h", obs_rs, obs_b, exp_rs, exp_b);
      end
    end
    exp_rd_exec = m_img[rd_addr];
    tick();
    rd_at_exec = rd_data;
    if (done) model_exec(exp_rs, exp_b);
    repeat (2) tick();
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b);
    if (m_four) begin
      send_nibble(rs, b[7:4]);
      send_nibble(rs, b[3:0]);
    end else begin
      send_nibble(rs, b[7:4]);
    end
  endtask

  task automatic wait_busy();
    int n = 0;
    while (busy === 1'b1 && n < 200) begin tick(); n++; end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles", busy, n);
    end else if (mon_last_run != DEPTH) begin
      n_fail++;
      $display("FAIL busy_length: got %0d cycles expected %0d", mon_last_run, DEPTH);
    end
    m_busy = 0;
  endtask

  task automatic test_reset();
    int n = 0;
    model_reset();
    tick();
    n_checks++;
    if (dut_vec() !== model_vec() || cmd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: got %h cv=%b rd=%h expected %h cv=0 rd=00",
               dut_vec(), cmd_valid, rd_data, model_vec());
    end
    reset_n = 1'b1;
    do begin tick(); n++; end while (busy === 1'b1 && n < 100);
    n_checks++;
    if (n != DEPTH) begin
      n_fail++;
      $display("FAIL reset_fill_len: got %0d expected %0d", n, DEPTH);
    end
    m_busy = 0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      tick();
      n_checks++;
      if (rd_data !== m_img[i]) begin
        n_fail++;
        $display("FAIL reset_image[%0d]: got %h expected %h", i, rd_data, m_img[i]);
      end
    end
  endtask

  task automatic test_init();
    int cv0 = mon_cv_count, m0 = m_cv_count;
    logic [3:0] seq [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
    foreach (seq[i]) send_nibble(1'b0, seq[i]);
    send_byte(1'b0, 8'h28);
    send_byte(1'b0, 8'h0C);
    send_byte(1'b0, 8'h01);
    wait_busy();
    send_byte(1'b0, 8'h06);
    n_checks++;
    if (mon_cv_count - cv0 != m_cv_count - m0) begin
      n_fail++;
      $display("FAIL init_cv_count: got %0d expected %0d", mon_cv_count - cv0, m_cv_count - m0);
    end
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL init_state: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_write();
    rd_addr = '0;
    send_nibble(1'b1, 4'h4);
    send_nibble(1'b0, 4'h8);
    n_checks++;
    if (rd_at_exec !== exp_rd_exec) begin
      n_fail++;
      $display("FAIL read_during_write: got %h expected %h", rd_at_exec, exp_rd_exec);
    end
    send_byte(1'b1, 8'h49);
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL write_state: got %h expected %h", dut_vec(), model_vec());
    end
    for (int i = 0; i < 2; i++) begin
      rd_addr = AW'(i);
      tick();
      n_checks++;
      if (rd_data !== m_img[i]) begin
        n_fail++;
        $display("FAIL write_image[%0d]: got %h expected %h", i, rd_data, m_img[i]);
      end
    end
  endtask

  task automatic test_addr_wrap();
    logic [7:0] seq [6] = '{8'hA7, 8'h58, 8'hCF, 8'h59, 8'hE7, 8'h5A};
    for (int i = 0; i < 6; i++) begin
      send_byte(i % 2 == 1, seq[i]);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL wrap_state[%0d]: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      tick();
      n_checks++;
      if (rd_data !== m_img[i]) begin
        n_fail++;
        $display("FAIL wrap_image[%0d]: got %h expected %h", i, rd_data, m_img[i]);
      end
    end
  endtask

  task automatic test_overrun();
    send_byte(1'b0, 8'h01);
    send_nibble(1'b1, 4'h5);
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL overrun_state: got %h expected %h", dut_vec(), model_vec());
    end
    wait_busy();
    send_byte(1'b1, 8'h51);
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL overrun_after: got %h expected %h", dut_vec(), model_vec());
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      tick();
      n_checks++;
      if (rd_data !== m_img[i]) begin
        n_fail++;
        $display("FAIL overrun_image[%0d]: got %h expected %h", i, rd_data, m_img[i]);
      end
    end
  endtask

  task automatic test_reset_midbyte();
    int n = 0;
    send_nibble(1'b0, 4'h8);
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL midbyte_reset: got %h expected %h", dut_vec(), model_vec());
    end
    tick();
    reset_n = 1'b1;
    do begin tick(); n++; end while (busy === 1'b1 && n < 100);
    m_busy = 0;
    send_nibble(1'b0, 4'h2);
    send_byte(1'b0, 8'h28);
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL midbyte_resume: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit rs;
    for (int it = 0; it < 60; it++) begin
      rs = 0;
      case ($urandom_range(0, 7))
        0, 1: begin rs = 1; b = 8'($urandom_range(32, 126)); end
        2:    b = 8'h80 | 8'($urandom_range(0, 127));
        3:    b = 8'h10 | 8'($urandom_range(0, 15));
        4:    b = 8'h04 | 8'($urandom_range(0, 3));
        5:    b = 8'h08 | 8'($urandom_range(0, 7));
        6:    b = 8'h20 | 8'($urandom_range(0, 15));
        default: case ($urandom_range(0, 2))
          0:       b = 8'h02 | 8'($urandom_range(0, 1));
          1:       b = 8'h40 | 8'($urandom_range(0, 63));
          default: b = 8'h00;
        endcase
      endcase
      send_byte(rs, b);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random_state[%0d] byte=%h rs=%b: got %h expected %h",
                 it, b, rs, dut_vec(), model_vec());
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      tick();
      n_checks++;
      if (rd_data !== m_img[i]) begin
        n_fail++;
        $display("FAIL random_image[%0d]: got %h expected %h", i, rd_data, m_img[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write();
    test_addr_wrap();
    test_overrun();
    test_reset_midbyte();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
